// File: rtl/gtc_pkg.sv
// gtc_pkg: shared state encoding, settle-counter width and 2-input truth tables for gate_truth_checker
package gtc_pkg;
    typedef enum logic [2:0] {IDLE, APPLY, WAIT, SAMPLE, DONE} state_t;
    localparam int SETTLE_W = 4;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
endpackage

// File: rtl/gtc_settle_timer.sv
// gtc_settle_timer: loadable down-counter that flags the last settle cycle of the WAIT state
import gtc_pkg::*;

module gtc_settle_timer (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                en,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                expired
);
    logic [SETTLE_W-1:0] cnt;

    // load on entry to WAIT, then count down once per WAIT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    end

    assign expired = cnt <= SETTLE_W'(1);
endmodule

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: drives every input vector into a gate and checks its output against TRUTH; GTC_FIRST_FAIL_EN adds first-failure capture
import gtc_pkg::*;

module gate_truth_checker #(
    parameter int                  N_IN       = 2,
    parameter logic [2**N_IN-1:0]  TRUTH      = TT_NOR,
    parameter int                  SETTLE_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count
`ifdef GTC_FIRST_FAIL_EN
    ,
    output logic            first_fail_vld,
    output logic [N_IN-1:0] first_fail_idx
`endif
);
    state_t          state, state_nxt;
    logic [N_IN-1:0] idx;
    logic            miss, last, expired;
    logic [N_IN:0]   err_nxt;

    gtc_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == APPLY),
        .en       (state == WAIT),
        .load_val (SETTLE_W'(SETTLE_CYC)),
        .expired  (expired)
    );

    // compare against the registered index so the expected bit always matches the applied vector
    assign miss    = dut_y != TRUTH[idx];
    assign last    = idx == {N_IN{1'b1}};
    assign err_nxt = err_count + (N_IN+1)'(miss);
    assign busy    = state inside {APPLY, WAIT, SAMPLE};
    assign done    = state == DONE;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? APPLY : IDLE;
            APPLY:   state_nxt = (SETTLE_CYC == 0) ? SAMPLE : WAIT;
            WAIT:    state_nxt = expired ? SAMPLE : WAIT;
            SAMPLE:  state_nxt = last ? DONE : APPLY;
            default: state_nxt = IDLE;
        endcase
    end

    // vector index, applied vector and run results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            vec_out   <= '0;
            err_count <= '0;
            pass      <= 1'b0;
`ifdef GTC_FIRST_FAIL_EN
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
`endif
        end else begin
            if (state == IDLE && start) begin
                idx       <= '0;
                err_count <= '0;
                pass      <= 1'b0;
`ifdef GTC_FIRST_FAIL_EN
                first_fail_vld <= 1'b0;
                first_fail_idx <= '0;
`endif
            end
            if (state == APPLY) vec_out <= idx;
            if (state == SAMPLE) begin
                err_count <= err_nxt;
                if (last) pass <= err_nxt == '0;
                else idx <= idx + 1'b1;
`ifdef GTC_FIRST_FAIL_EN
                if (miss && !first_fail_vld) begin
                    first_fail_vld <= 1'b1;
                    first_fail_idx <= idx;
                end
`endif
            end
        end
    end
endmodule
